m1553_receiver: RTL

Decodes one MIL-STD-1553 Manchester-II bipolar word stream: 3-bit sync, 16 data bits, odd parity, 20 bit times total. It is the receive counterpart of the 1553 word transmitter. It sits behind the bus transceiver's two comparator outputs and hands decoded 16-bit words, sync type and error flags to the terminal protocol logic. Word boundaries are timed from the first non-null sample, and contiguous (gapless) words are decoded back to back.

---
 rtl/m1553_receiver.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/m1553_receiver.sv
// MIL-STD-1553 Manchester-II word receiver: 3-bit sync, 16 data bits, odd parity.
// Samples each half-bit at mid-point from a timebase anchored on the first non-null level.
`default_nettype none

package lib_1553;
  typedef logic [15:0] word_t;
endpackage

module m1553_receiver #(
  parameter int CLKS_PER_HALF_BIT = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_rx_pos,
  input  logic            i_rx_neg,
  input  logic            i_en,
  output lib_1553::word_t o_data,
  output logic            o_cmd_sync,
  output logic            o_valid,
  output logic            o_parity_err,
  output logic            o_manch_err,
  output logic            o_busy
);

  localparam int            CW   = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_HALF_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RECV, CHAIN} state_t;

  state_t          state_q, state_d;
  logic            pos_meta_q, pos_sync_q, neg_meta_q, neg_sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      k_q, k_d;
  logic            first_q, first_d;
  logic            half_q, half_d;
  logic [15:0]     shift_q, shift_d;
  lib_1553::word_t data_q, data_d;
  logic            cmd_q, cmd_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            merr_q, merr_d;
  logic            busy_q, busy_d;

  logic lvl_h, lvl_l, lvl_ok, lvl_inv, sample, ok;

  assign lvl_h   = pos_sync_q & ~neg_sync_q;
  assign lvl_l   = ~pos_sync_q & neg_sync_q;
  assign lvl_ok  = lvl_h | lvl_l;
  assign lvl_inv = pos_sync_q & neg_sync_q;
  assign sample  = (cnt_q == HALF);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    k_d     = (cnt_q == LAST) ? ((k_q == 6'd39) ? 6'd0 : k_q + 6'd1) : k_q;
    first_d = first_q;
    half_d  = half_q;
    shift_d = shift_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    merr_d  = 1'b0;
    ok      = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        k_d   = 6'd0;
        if (lvl_ok) begin
          // The leading edge cycle counts as phase 0, so the next cycle is phase 1.
          state_d = RECV;
          cnt_d   = ONE;
          first_d = lvl_h;
        end
      end
      RECV: begin
        if (sample) begin
          if (k_q < 6'd3) begin
            ok = lvl_ok && (lvl_h == first_q);
          end else if (k_q < 6'd6) begin
            ok = lvl_ok && (lvl_h != first_q);
          end else if (!k_q[0]) begin
            ok     = lvl_ok;
            half_d = lvl_h;
          end else begin
            ok      = lvl_ok && (lvl_h != half_q);
            shift_d = {shift_q[14:0], half_q};
          end

          if (!ok) begin
            merr_d  = 1'b1;
            state_d = IDLE;
          end else if (k_q == 6'd39) begin
            // half_q is the parity bit; shift_q holds the 16 data bits, MSB first.
            data_d  = shift_q;
            cmd_d   = first_q;
            valid_d = ^{shift_q, half_q};
            perr_d  = ~(^{shift_q, half_q});
            state_d = CHAIN;
          end
        end
      end
      CHAIN: begin
        // Busy is held across this window since a gapless follow-on word is only visible here.
        if (sample && (k_q == 6'd0)) begin
          if (lvl_ok) begin
            state_d = RECV;
            first_d = lvl_h;
          end else begin
            merr_d  = lvl_inv;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_en) begin
      state_d = IDLE;
      data_d  = data_q;
      cmd_d   = cmd_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      merr_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      pos_meta_q <= 1'b0;
      pos_sync_q <= 1'b0;
      neg_meta_q <= 1'b0;
      neg_sync_q <= 1'b0;
      cnt_q      <= '0;
      k_q        <= 6'd0;
      first_q    <= 1'b0;
      half_q     <= 1'b0;
      shift_q    <= 16'h0000;
      data_q     <= 16'h0000;
      cmd_q      <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      merr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_meta_q <= i_rx_pos;
      pos_sync_q <= pos_meta_q;
      neg_meta_q <= i_rx_neg;
      neg_sync_q <= neg_meta_q;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      first_q    <= first_d;
      half_q     <= half_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      merr_q     <= merr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_cmd_sync   = cmd_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_manch_err  = merr_q;
  assign o_busy       = busy_q;

endmodule

`default_nettype wire
